// File: rtl/sdram_init_monitor.sv
// Watches the SDRAM command bus from reset and checks the JEDEC power-up/init
// sequence (precharge-all, auto-refreshes, mode-register load) and its timing.
module sdram_init_monitor #(
  parameter int unsigned CLK              = 100_000_000,
  parameter int unsigned TPOWERUP         = 200,
  parameter int unsigned TRP              = 20,
  parameter int unsigned TRFC             = 70,
  parameter int unsigned TMRD             = 2,
  parameter int unsigned MIN_AUTO_REFRESH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  cmd,
  input  logic [1:0]  ba,
  input  logic [12:0] addr,
  output logic        init_ok,
  output logic        err,
  output logic [2:0]  err_code,
  output logic [2:0]  ref_count,
  output logic [2:0]  mr_cas,
  output logic [2:0]  mr_bl,
  output logic        mr_bt,
  output logic        mr_wb
);

  localparam int unsigned NS_PER_CLK   = (CLK > 1_000_000_000) ? 1 : (1_000_000_000 / CLK);
  localparam int unsigned CLK_POWER_UP = TPOWERUP / NS_PER_CLK;
  localparam int unsigned CLK_TRP      = TRP / NS_PER_CLK;
  localparam int unsigned CLK_TRFC     = TRFC / NS_PER_CLK;
  localparam int unsigned MAX_A        = (CLK_POWER_UP > CLK_TRP) ? CLK_POWER_UP : CLK_TRP;
  localparam int unsigned MAX_B        = (CLK_TRFC > TMRD) ? CLK_TRFC : TMRD;
  localparam int unsigned MAX_CNT      = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_REQ      = $clog2(MAX_CNT + 2);
  localparam int unsigned CNT_W        = (CNT_REQ > 8) ? CNT_REQ : 8;

  localparam logic [2:0] E_TIMING   = 3'd1;
  localparam logic [2:0] E_ORDER    = 3'd2;
  localparam logic [2:0] E_PRE_ONE  = 3'd3;
  localparam logic [2:0] E_FEW_REF  = 3'd4;
  localparam logic [2:0] E_REF_OVF  = 3'd5;
  localparam logic [2:0] E_MR_FIELD = 3'd6;

  typedef enum logic [3:0] {
    PWRUP, WAIT_PRE, TRP_WAIT, WAIT_REF, TRFC_WAIT,
    WAIT_REF_OR_MR, TMRD_WAIT, READY, ERROR
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic               init_ok_q, init_ok_d;
  logic               err_q, err_d;
  logic [2:0]         err_code_q, err_code_d;
  logic [2:0]         ref_count_q, ref_count_d;
  logic [2:0]         mr_cas_q, mr_cas_d;
  logic [2:0]         mr_bl_q, mr_bl_d;
  logic               mr_bt_q, mr_bt_d;
  logic               mr_wb_q, mr_wb_d;

  logic               is_idle, is_pre, is_ref, is_lmr;
  logic               viol;
  logic [2:0]         viol_code;
  logic               wait_busy, mr_allowed, mr_fields_ok;

  // Command decode; INHIBIT (CS_n high) and NOP are both idle.
  always_comb begin
    is_idle = cmd[3] || (cmd == 4'b0111);
    is_pre  = (cmd == 4'b0010);
    is_ref  = (cmd == 4'b0001);
    is_lmr  = (cmd == 4'b0000);
  end

  always_comb begin
    cnt_inc      = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    wait_busy    = ((state_q == TRP_WAIT)  && (cnt_q < CNT_W'(CLK_TRP))) ||
                   ((state_q == TRFC_WAIT) && (cnt_q < CNT_W'(CLK_TRFC)));
    mr_allowed   = (state_q == TRFC_WAIT) || (state_q == WAIT_REF_OR_MR);
    mr_fields_ok = (ba == 2'b00) && (addr[12:10] == 3'b000) && (addr[8:7] == 2'b00) &&
                   ((addr[6:4] == 3'b001) || (addr[6:4] == 3'b010) || (addr[6:4] == 3'b011));
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_inc;
    init_ok_d   = init_ok_q;
    err_d       = err_q;
    err_code_d  = err_code_q;
    ref_count_d = ref_count_q;
    mr_cas_d    = mr_cas_q;
    mr_bl_d     = mr_bl_q;
    mr_bt_d     = mr_bt_q;
    mr_wb_d     = mr_wb_q;
    viol        = 1'b0;
    viol_code   = 3'd0;

    case (state_q)
      PWRUP: begin
        if (!is_idle) begin
          viol      = 1'b1;
          viol_code = E_TIMING;
        end else if (cnt_inc >= CNT_W'(CLK_POWER_UP)) begin
          state_d = WAIT_PRE;
        end
      end
      WAIT_PRE: begin
        if (is_pre && addr[10]) begin
          state_d = TRP_WAIT;
          cnt_d   = CNT_W'(1);
        end else if (is_pre) begin
          viol      = 1'b1;
          viol_code = E_PRE_ONE;
        end else if (!is_idle) begin
          viol      = 1'b1;
          viol_code = E_ORDER;
        end
      end
      TRP_WAIT, WAIT_REF, TRFC_WAIT, WAIT_REF_OR_MR: begin
        if (!is_idle && wait_busy) begin
          viol      = 1'b1;
          viol_code = E_TIMING;
        end else if (is_ref) begin
          if (ref_count_q == 3'd7) begin
            viol      = 1'b1;
            viol_code = E_REF_OVF;
          end else begin
            ref_count_d = ref_count_q + 3'd1;
            state_d     = TRFC_WAIT;
            cnt_d       = CNT_W'(1);
          end
        end else if (is_lmr && mr_allowed) begin
          if (32'(ref_count_q) < MIN_AUTO_REFRESH) begin
            viol      = 1'b1;
            viol_code = E_FEW_REF;
          end else if (!mr_fields_ok) begin
            viol      = 1'b1;
            viol_code = E_MR_FIELD;
          end else begin
            mr_cas_d  = addr[6:4];
            mr_bl_d   = addr[2:0];
            mr_bt_d   = addr[3];
            mr_wb_d   = addr[9];
            cnt_d     = CNT_W'(1);
            state_d   = (TMRD <= 1) ? READY : TMRD_WAIT;
            init_ok_d = (TMRD <= 1);
          end
        end else if (!is_idle) begin
          viol      = 1'b1;
          viol_code = E_ORDER;
        end else if (!wait_busy) begin
          if (state_q == TRP_WAIT)  state_d = WAIT_REF;
          if (state_q == TRFC_WAIT) state_d = WAIT_REF_OR_MR;
        end
      end
      TMRD_WAIT: begin
        if (!is_idle) begin
          viol      = 1'b1;
          viol_code = E_TIMING;
        end else if (cnt_inc >= CNT_W'(TMRD)) begin
          state_d   = READY;
          init_ok_d = 1'b1;
        end
      end
      READY: ;
      ERROR: ;
      default: state_d = ERROR;
    endcase

    // First violation wins; ERROR is absorbing so later commands never reach here.
    if (viol) begin
      state_d    = ERROR;
      err_d      = 1'b1;
      err_code_d = viol_code;
      init_ok_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PWRUP;
      cnt_q       <= '0;
      init_ok_q   <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 3'd0;
      ref_count_q <= 3'd0;
      mr_cas_q    <= 3'd0;
      mr_bl_q     <= 3'd0;
      mr_bt_q     <= 1'b0;
      mr_wb_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_ok_q   <= init_ok_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      ref_count_q <= ref_count_d;
      mr_cas_q    <= mr_cas_d;
      mr_bl_q     <= mr_bl_d;
      mr_bt_q     <= mr_bt_d;
      mr_wb_q     <= mr_wb_d;
    end
  end

  assign init_ok   = init_ok_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign ref_count = ref_count_q;
  assign mr_cas    = mr_cas_q;
  assign mr_bl     = mr_bl_q;
  assign mr_bt     = mr_bt_q;
  assign mr_wb     = mr_wb_q;

endmodule

// File: tb/tb_sdram_init_monitor.sv
// Directed bench for sdram_init_monitor at default parameters
// (power-up 20 cycles, tRP 2, tRFC 7, tMRD 2).
module tb_sdram_init_monitor;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] INH = 4'b1111;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] REF = 4'b0001;
  localparam logic [3:0] LMR = 4'b0000;
  localparam logic [3:0] ACT = 4'b0011;

  logic        clk;
  logic        rst_n;
  logic [3:0]  cmd;
  logic [1:0]  ba;
  logic [12:0] addr;
  logic        init_ok;
  logic        err;
  logic [2:0]  err_code;
  logic [2:0]  ref_count;
  logic [2:0]  mr_cas;
  logic [2:0]  mr_bl;
  logic        mr_bt;
  logic        mr_wb;

  int n_tests = 0;
  int n_fail  = 0;

  sdram_init_monitor dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd       (cmd),
    .ba        (ba),
    .addr      (addr),
    .init_ok   (init_ok),
    .err       (err),
    .err_code  (err_code),
    .ref_count (ref_count),
    .mr_cas    (mr_cas),
    .mr_bl     (mr_bl),
    .mr_bt     (mr_bt),
    .mr_wb     (mr_wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Drive one command for one clock; returns 1ns after the sampling edge.
  task automatic cyc(input logic [3:0] c, input logic [12:0] a);
    cmd  = c;
    addr = a;
    @(posedge clk);
    #1;
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) cyc(NOP, 13'h0);
  endtask

  task automatic do_reset();
    cmd   = NOP;
    addr  = 13'h0;
    ba    = 2'b00;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Power-up wait, precharge-all, one NOP (tRP = 2).
  task automatic front_end();
    nops(20);
    cyc(PRE, 13'h1FFF);
    nops(1);
  endtask

  initial begin
    rst_n = 1'b1;
    cmd   = NOP;
    ba    = 2'b00;
    addr  = 13'h0;

    // Reset values
    do_reset();
    check("rst_init_ok", 32'(init_ok), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    check("rst_ref_count", 32'(ref_count), 32'd0);
    check("rst_mr", {20'd0, mr_cas, mr_bl, mr_bt, mr_wb, 4'd0}, 32'd0);

    // Legal sequence
    front_end();
    for (int r = 0; r < 2; r++) begin
      cyc(REF, 13'h0);
      nops(6);
    end
    check("legal_ref_count", 32'(ref_count), 32'd2);
    cyc(LMR, 13'h0027);
    check("legal_init_ok_early", 32'(init_ok), 32'd0);
    check("legal_mr_cas", 32'(mr_cas), 32'd2);
    check("legal_mr_bl", 32'(mr_bl), 32'd7);
    check("legal_mr_bt_wb", {30'd0, mr_bt, mr_wb}, 32'd0);
    nops(1);
    check("legal_init_ok", 32'(init_ok), 32'd1);
    check("legal_err", 32'(err), 32'd0);
    // Anything goes once ready; captured fields frozen
    cyc(PRE, 13'h0000);
    cyc(LMR, 13'h0247);
    cyc(REF, 13'h0);
    cyc(ACT, 13'h0123);
    check("ready_init_ok", 32'(init_ok), 32'd1);
    check("ready_err", 32'(err), 32'd0);
    check("ready_frozen", {24'd0, ref_count, mr_cas, mr_bl[2:1]}, {24'd0, 3'd2, 3'd2, 2'b11});

    // Reset from READY discards everything
    do_reset();
    check("rst_ready_init_ok", 32'(init_ok), 32'd0);
    check("rst_ready_fields", {23'd0, ref_count, mr_cas, mr_bl}, 32'd0);

    // Precharge at cycle 10 (INHIBIT mixed in as idle)
    nops(5);
    for (int i = 0; i < 5; i++) cyc(INH, 13'h1FFF);
    check("pwr10_no_err_yet", 32'(err), 32'd0);
    cyc(PRE, 13'h1FFF);
    check("pwr10_err", 32'(err), 32'd1);
    check("pwr10_code", 32'(err_code), 32'd1);
    nops(30);
    check("pwr10_init_ok", 32'(init_ok), 32'd0);
    check("pwr10_sticky", {28'd0, err, err_code}, {28'd0, 1'b1, 3'd1});

    // Precharge one cycle early (cycle 19)
    do_reset();
    check("rst_err_clear", {28'd0, err, err_code}, 32'd0);
    nops(19);
    cyc(PRE, 13'h1FFF);
    check("pwr19_code", 32'(err_code), 32'd1);

    // Precharge without A10
    do_reset();
    nops(20);
    cyc(PRE, 13'h0000);
    check("pre_a10_code", 32'(err_code), 32'd3);

    // Non-precharge first command
    do_reset();
    nops(20);
    cyc(REF, 13'h0);
    check("order_code", 32'(err_code), 32'd2);

    // Auto-refresh 3 cycles after previous auto-refresh
    do_reset();
    front_end();
    cyc(REF, 13'h0);
    nops(2);
    cyc(REF, 13'h0);
    check("ref3_code", 32'(err_code), 32'd1);
    check("ref3_count", 32'(ref_count), 32'd1);

    // Auto-refresh one cycle before tRFC expires
    do_reset();
    front_end();
    cyc(REF, 13'h0);
    nops(5);
    cyc(REF, 13'h0);
    check("ref6_code", 32'(err_code), 32'd1);

    // Auto-refresh one cycle before tRP expires
    do_reset();
    nops(20);
    cyc(PRE, 13'h1FFF);
    cyc(REF, 13'h0);
    check("trp1_code", 32'(err_code), 32'd1);

    // LMR after a single auto-refresh
    do_reset();
    front_end();
    cyc(REF, 13'h0);
    nops(6);
    cyc(LMR, 13'h0027);
    check("lmr_few_code", 32'(err_code), 32'd4);
    check("lmr_few_mr", 32'(mr_cas), 32'd0);

    // LMR with CAS latency 4
    do_reset();
    front_end();
    for (int r = 0; r < 2; r++) begin
      cyc(REF, 13'h0);
      nops(6);
    end
    cyc(LMR, 13'h0047);
    check("lmr_cas4_code", 32'(err_code), 32'd6);
    check("lmr_cas4_init_ok", 32'(init_ok), 32'd0);

    // Command during tMRD
    do_reset();
    front_end();
    for (int r = 0; r < 2; r++) begin
      cyc(REF, 13'h0);
      nops(6);
    end
    cyc(LMR, 13'h0231);
    check("lmr_fields", {24'd0, mr_cas, mr_bl, mr_bt, mr_wb}, {24'd0, 3'd3, 3'd1, 1'b0, 1'b1});
    cyc(ACT, 13'h0);
    check("tmrd_code", 32'(err_code), 32'd1);

    // Eight auto-refreshes
    do_reset();
    front_end();
    for (int r = 0; r < 7; r++) begin
      cyc(REF, 13'h0);
      nops(6);
    end
    check("ref7_count", 32'(ref_count), 32'd7);
    check("ref7_err", 32'(err), 32'd0);
    cyc(REF, 13'h0);
    check("ref8_code", 32'(err_code), 32'd5);
    check("ref8_count", 32'(ref_count), 32'd7);

    // Reset asserted mid-sequence, then legal sequence
    do_reset();
    front_end();
    cyc(REF, 13'h0);
    nops(3);
    rst_n = 1'b0;
    #3;
    check("mid_rst_async", 32'(ref_count), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    front_end();
    for (int r = 0; r < 2; r++) begin
      cyc(REF, 13'h0);
      nops(6);
    end
    cyc(LMR, 13'h0027);
    nops(1);
    check("mid_rst_init_ok", 32'(init_ok), 32'd1);
    check("mid_rst_err", 32'(err), 32'd0);
    check("mid_rst_ref_count", 32'(ref_count), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
